// File: rtl/gennum_spi_pkg.sv
// Shared constants, command field positions and FSM encoding for the GS2961 SPI responder.
package gennum_spi_pkg;

    localparam int unsigned CMD_W        = 16;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CMD_RW_BIT   = 15;
    localparam int unsigned CMD_AINC_BIT = 12;
    localparam int unsigned ADDR_MSB     = ADDR_W - 1;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] CMD     = 3'd1;
    localparam logic [STATE_W-1:0] RD_DATA = 3'd2;
    localparam logic [STATE_W-1:0] WR_DATA = 3'd3;
    localparam logic [STATE_W-1:0] DONE    = 3'd4;

    // True when a 12-bit register address maps onto an implemented register.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned num_regs);
        return {20'd0, addr} < num_regs;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-stage synchronizer for one SPI pin with registered rise/fall event pulses.
module spi_slave_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   last;

    assign last = sync_q[SYNC_STAGES-1];

    // Edge events land SYNC_STAGES+1 clocks after the pin edge.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= last;
            rise   <= last & ~prev_q;
            fall   <= ~last & prev_q;
        end
    end

endmodule

// File: rtl/gennum2961_spi_slave.sv
// GS2961 host-interface SPI responder with locally loadable register file.
// Optional burst addressing (command bit 12) enabled by GENNUM_SPI_SLAVE_AUTO_INC_EN.
module gennum2961_spi_slave
    import gennum_spi_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                spi_cs,
    input  logic                spi_sck,
    input  logic                spi_mosi,
    output logic                spi_miso,
    input  logic                loc_wr,
    input  logic [ADDR_W-1:0]   loc_addr,
    input  logic [CMD_W-1:0]    loc_wdata,
    output logic                spi_wr_strobe,
    output logic [ADDR_W-1:0]   spi_wr_addr,
    output logic [CMD_W-1:0]    spi_wr_data,
    output logic                addr_err
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef GENNUM_SPI_SLAVE_AUTO_INC_EN
    localparam logic AINC_EN = 1'b1;
`else
    localparam logic AINC_EN = 1'b0;
`endif

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES:0] mosi_q;
    logic mosi_s;

    logic [STATE_W-1:0] state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_m1;
    logic [CMD_W-1:0]   sh_q, sh_n, rd_q, rd_n, word_c, snap_c;
    logic [ADDR_W-1:0]  addr_q, addr_n, cmd_addr_c, next_addr_c, snap_addr_c;
    logic               rng_q, rng_n, armed_q, armed_n, burst_q, burst_n;
    logic               miso_n, strobe_n, err_n, spi_we;
    logic [ADDR_W-1:0]  waddr_n;
    logic [CMD_W-1:0]   wdata_n;
    logic [CMD_W-1:0]   regs_q [NUM_REGS];

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_b(rst_b),
        .din  (spi_cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst_b(rst_b),
        .din  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // One extra stage keeps MOSI aligned with the registered sck event.
    always_ff @(posedge clk) begin
        if (!rst_b) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-1:0], spi_mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES];

    assign word_c      = {sh_q[CMD_W-2:0], mosi_s};
    assign cmd_addr_c  = word_c[ADDR_MSB:0];
    assign next_addr_c = addr_q + 12'd1;
    assign cnt_m1      = cnt_q - 4'd1;
    assign snap_addr_c = (state_q == CMD) ? cmd_addr_c : next_addr_c;
    assign snap_c      = in_range(snap_addr_c, NUM_REGS) ? regs_q[IDX_W'(snap_addr_c)] : '0;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            cnt_q         <= '1;
            sh_q          <= '0;
            rd_q          <= '0;
            addr_q        <= '0;
            rng_q         <= 1'b0;
            armed_q       <= 1'b0;
            burst_q       <= 1'b0;
            spi_miso      <= 1'b0;
            spi_wr_strobe <= 1'b0;
            spi_wr_addr   <= '0;
            spi_wr_data   <= '0;
            addr_err      <= 1'b0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            sh_q          <= sh_n;
            rd_q          <= rd_n;
            addr_q        <= addr_n;
            rng_q         <= rng_n;
            armed_q       <= armed_n;
            burst_q       <= burst_n;
            spi_miso      <= miso_n;
            spi_wr_strobe <= strobe_n;
            spi_wr_addr   <= waddr_n;
            spi_wr_data   <= wdata_n;
            addr_err      <= err_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        sh_n     = sh_q;
        rd_n     = rd_q;
        addr_n   = addr_q;
        rng_n    = rng_q;
        armed_n  = armed_q;
        burst_n  = burst_q;
        miso_n   = spi_miso;
        strobe_n = 1'b0;
        waddr_n  = spi_wr_addr;
        wdata_n  = spi_wr_data;
        err_n    = 1'b0;
        spi_we   = 1'b0;

        if (cs_rise) begin
            state_n = IDLE;
            cnt_n   = '1;
            miso_n  = 1'b0;
            armed_n = 1'b0;
            burst_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_n = 1'b0;
                    cnt_n  = '1;
                    if (cs_fall) state_n = CMD;
                end
                CMD: begin
                    if (sck_rise) begin
                        sh_n  = word_c;
                        cnt_n = cnt_m1;
                        if (cnt_q == '0) begin
                            addr_n  = cmd_addr_c;
                            rng_n   = in_range(cmd_addr_c, NUM_REGS);
                            err_n   = ~in_range(cmd_addr_c, NUM_REGS);
                            burst_n = AINC_EN & word_c[CMD_AINC_BIT];
                            cnt_n   = '1;
                            armed_n = 1'b0;
                            if (word_c[CMD_RW_BIT]) begin
                                rd_n    = snap_c;
                                miso_n  = snap_c[CMD_W-1];
                                state_n = RD_DATA;
                            end else begin
                                state_n = WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    // The fall closing the last command bit is not a data shift; only falls after a data rise are.
                    if (sck_rise) begin
                        armed_n = 1'b1;
                    end else if (sck_fall && armed_q) begin
                        armed_n = 1'b0;
                        if (cnt_q != '0) begin
                            miso_n = rd_q[cnt_m1];
                            cnt_n  = cnt_m1;
                            if (cnt_q == 4'd1 && !burst_q) state_n = DONE;
                        end else begin
                            addr_n = next_addr_c;
                            rng_n  = in_range(next_addr_c, NUM_REGS);
                            err_n  = ~in_range(next_addr_c, NUM_REGS);
                            rd_n   = snap_c;
                            miso_n = snap_c[CMD_W-1];
                            cnt_n  = '1;
                        end
                    end
                end
                WR_DATA: begin
                    if (sck_rise) begin
                        sh_n  = word_c;
                        cnt_n = cnt_m1;
                        if (cnt_q == '0) begin
                            cnt_n = '1;
                            if (rng_q) begin
                                spi_we   = 1'b1;
                                strobe_n = 1'b1;
                                waddr_n  = addr_q;
                                wdata_n  = word_c;
                            end
                            if (burst_q) begin
                                addr_n = next_addr_c;
                                rng_n  = in_range(next_addr_c, NUM_REGS);
                                err_n  = ~in_range(next_addr_c, NUM_REGS);
                            end else begin
                                state_n = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (sck_fall) miso_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Local writes are applied after SPI commits so they win an address collision.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (spi_we) regs_q[IDX_W'(addr_q)] <= word_c;
            if (loc_wr && in_range(loc_addr, NUM_REGS)) regs_q[IDX_W'(loc_addr)] <= loc_wdata;
        end
    end

endmodule

// File: tb/tb_gennum2961_spi_slave.sv
// Directed bench for gennum2961_spi_slave: mode-0 controller, register model and per-cycle output checks.
module tb_gennum2961_spi_slave;

    localparam int NREG = 64;

    logic        clk = 1'b0;
    logic        rst_b, spi_cs, spi_sck, spi_mosi, loc_wr;
    logic [11:0] loc_addr;
    logic [15:0] loc_wdata;
    logic        spi_miso, spi_wr_strobe, addr_err;
    logic [11:0] spi_wr_addr;
    logic [15:0] spi_wr_data;

    gennum2961_spi_slave #(.NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .spi_cs       (spi_cs),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .loc_wr       (loc_wr),
        .loc_addr     (loc_addr),
        .loc_wdata    (loc_wdata),
        .spi_wr_strobe(spi_wr_strobe),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model [NREG];
    logic [11:0] exp_wa_q [$];
    logic [15:0] exp_wd_q [$];
    int          exp_err = 0, got_err = 0, exp_str = 0, got_str = 0;
    int          cs_hi = 0;
    logic        live = 1'b0;
    logic        rst_at_edge = 1'b0;
    logic [15:0] rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic loc_write(input logic [11:0] a, input logic [15:0] d);
        loc_wr = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk);
        loc_wr = 1'b0;
        if (a < NREG) model[a[5:0]] = d;
    endtask

    // Mode-0 transfer; stop_after<32 raises cs early; lw_bit>=0 injects a local write to the same
    // address three clocks after the rising sck of that data bit.
    task automatic xfer(input logic [15:0] cmd, input logic [15:0] wd, input int half, input int gap,
                        input int stop_after, input int lw_bit, input logic [15:0] lw_data,
                        output logic [15:0] rdo);
        logic [11:0] a;
        logic [31:0] stream;
        logic [15:0] exp_rd;
        bit          full, inr, is_rd;
        a      = cmd[11:0];
        stream = {cmd, wd};
        full   = stop_after >= 32;
        inr    = a < NREG;
        is_rd  = cmd[15];
        exp_rd = inr ? model[a[5:0]] : 16'h0000;
        if (stop_after >= 16 && !inr) exp_err++;
        if (full && !is_rd && inr) begin
            exp_wa_q.push_back(a); exp_wd_q.push_back(wd); exp_str++;
        end
        rdo = '0;
        spi_cs = 1'b0;
        wait_n(half);
        for (int i = 0; i < 32 && i < stop_after; i++) begin
            if (i == 16) wait_n(gap * 2 * half);
            spi_mosi = stream[31-i];
            wait_n(half);
            spi_sck = 1'b1;
            if (i >= 16) rdo[31-i] = spi_miso;
            if (i == 31 && full && !is_rd && inr) model[a[5:0]] = wd;
            if (i >= 16 && (31 - i) == lw_bit) begin
                wait_n(3);
                loc_write(a, lw_data);
                wait_n(half - 4);
            end else begin
                wait_n(half);
            end
            spi_sck = 1'b0;
        end
        wait_n(half);
        spi_cs = 1'b1;
        wait_n(8);
        if (full && is_rd) chk("rd_vs_model", rdo, exp_rd);
        chk("addr_err_pulses", got_err, exp_err);
        chk("strobe_count", got_str, exp_str);
    endtask

    always @(posedge clk) begin
        rst_at_edge <= ~rst_b;
        if (!rst_b) live <= 1'b1;
        cs_hi <= spi_cs ? cs_hi + 1 : 0;
    end

    // Per-cycle output checks against the model's expectations.
    always @(negedge clk) begin
        if (live) begin
            if (rst_at_edge) begin
                chk("rst_miso", spi_miso, 0);
                chk("rst_strobe", spi_wr_strobe, 0);
                chk("rst_wr_addr", spi_wr_addr, 0);
                chk("rst_wr_data", spi_wr_data, 0);
                chk("rst_addr_err", addr_err, 0);
            end else begin
                if (cs_hi >= 6) chk("idle_miso", spi_miso, 0);
                if (addr_err) got_err++;
                if (spi_wr_strobe) begin
                    got_str++;
                    if (exp_wa_q.size() == 0) begin
                        chk("unexpected_strobe", spi_wr_strobe, 0);
                    end else begin
                        chk("wr_addr", spi_wr_addr, exp_wa_q.pop_front());
                        chk("wr_data", spi_wr_data, exp_wd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        loc_wr = 1'b0; loc_addr = '0; loc_wdata = '0;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // 1: reset and idle with sck toggling under a high chip select
        repeat (6) begin @(negedge clk); spi_sck = ~spi_sck; end
        @(negedge clk); rst_b = 1'b1;
        repeat (12) begin @(negedge clk); spi_sck = ~spi_sck; end
        spi_sck = 1'b0;
        wait_n(6);
        chk("t1_no_strobe", got_str, 0);

        // 2: local load then read with an idle gap
        loc_write(12'h01F, 16'h0465);
        xfer(16'h801F, 16'h0000, 10, 5, 32, -1, 16'h0, rd);
        chk("t2_rd", rd, 16'h0465);
        chk("t2_no_err", got_err, 0);

        // 3: SPI write then read back
        xfer(16'h0020, 16'hABCD, 10, 1, 32, -1, 16'h0, rd);
        chk("t3_one_strobe", got_str, 1);
        xfer(16'h8020, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("t3_rd", rd, 16'hABCD);

        // 4: out-of-range read
        xfer(16'h8800, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("t4_rd_zero", rd, 16'h0000);
        chk("t4_err_once", got_err, 1);

        // Range boundaries: last register, first illegal address, no aliasing onto register 0
        loc_write(12'h040, 16'hDEAD);
        loc_write(12'hFFF, 16'hDEAD);
        loc_write(12'h03F, 16'hBEEF);
        xfer(16'h803F, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("last_reg_rd", rd, 16'hBEEF);
        xfer(16'h8040, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("first_oob_rd", rd, 16'h0000);
        xfer(16'h0040, 16'h1111, 10, 1, 32, -1, 16'h0, rd);
        chk("oob_write_err", got_err, 3);
        xfer(16'h8000, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("reg0_not_aliased", rd, 16'h0000);

        // 5: aborted command and aborted write, then a clean read
        loc_write(12'h006, 16'h1234);
        xfer(16'h8006, 16'h0000, 10, 1, 10, -1, 16'h0, rd);
        xfer(16'h0006, 16'hFFFF, 10, 1, 23, -1, 16'h0, rd);
        chk("t5_no_strobe", got_str, 1);
        xfer(16'h8006, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("t5_rd", rd, 16'h1234);

        // 6: local write collides with the SPI commit
        xfer(16'h0007, 16'hAAAA, 10, 1, 32, 0, 16'h5555, rd);
        chk("t6_strobe", got_str, 2);
        xfer(16'h8007, 16'h0000, 10, 1, 32, -1, 16'h0, rd);
        chk("t6_local_wins", rd, 16'h5555);

        // Snapshot: local write mid-read does not change the outgoing word
        xfer(16'h801F, 16'h0000, 10, 1, 32, 10, 16'h7777, rd);
        chk("snap_old", rd, 16'h0465);
        xfer(16'h801F, 16'h0000, 10, 0, 32, -1, 16'h0, rd);
        chk("snap_new", rd, 16'h7777);

        // Minimum bit period of 8 clocks
        xfer(16'h0030, 16'h5A5A, 4, 1, 32, -1, 16'h0, rd);
        xfer(16'h8030, 16'h0000, 4, 1, 32, -1, 16'h0, rd);
        chk("fast_rd", rd, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
